mouse_packet_tracker: RTL and testbench
=======================================

// Module: mouse_packet_tracker
// PURPOSE
//  Upstream feeder of the calculator logic. Consumes 3-byte PS/2 mouse movement packets from the byte receiver,
//  accumulates signed X/Y deltas into an absolute cursor clamped to the visible screen, and drives
//  mousex/mousey/mouseclick, which the calculator hit-tests against its button grid.
//  Also emits a one-cycle click pulse so downstream logic can act once per press.
// PARAMETERS
//  SCREEN_W    640      visible width; mousex range 0..SCREEN_W-1
//  SCREEN_H    480      visible height; mousey range 0..SCREEN_H-1
//  X_INIT      320      cursor X after reset
//  Y_INIT      240      cursor Y after reset
//  TIMEOUT     100000   idle clk cycles between bytes of one packet before the packet is abandoned
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst_n        in   1   synchronous reset, active-low
//  rx_byte      in   8   received PS/2 byte
//  rx_valid     in   1   1-cycle strobe: rx_byte valid this cycle
//  mousex       out  10  cursor X, registered
//  mousey       out  10  cursor Y, registered (0 = top)
//  mouseclick   out  1   left button level from last good packet
//  right_click  out  1   right button level from last good packet
//  click_pulse  out  1   1-cycle pulse on left-button 0->1 transition
//  pkt_done     out  1   1-cycle pulse when a packet is applied
//  sync_err     out  1   1-cycle pulse when a byte is dropped for framing
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): mousex=X_INIT, mousey=Y_INIT, all other outputs 0, FSM=B0, timeout counter 0.
//  FSM states B0, B1, B2; advance only on rx_valid.
//   B0: accept byte only if bit3==1 (sync bit) -> store flags, go B1; else pulse sync_err, stay B0.
//   B1: store X delta byte -> B2.  B2: store Y delta byte, apply packet -> B0.
//  Byte 0 fields: [0]=left, [1]=right, [4]=X sign, [5]=Y sign, [6]=X ovf, [7]=Y ovf.
//  Deltas: 9-bit two's complement {sign, byte}; range -256..+255.
//  Overflow bit set -> that axis delta treated as 0 (buttons still applied).
//  Apply (registered the cycle after the B2 byte's rx_valid; latency 1 clk):
//   nx = mousex + dx, ny = mousey - dy (PS/2 Y positive = up), computed in 12-bit signed.
//   Clamp: <0 -> 0; >SIZE-1 -> SIZE-1; X and Y independent.
//   mouseclick/right_click <= packet bits; pkt_done=1; click_pulse=1 iff new left=1 and previous mouseclick=0.
//  Outputs are not updated for partial or dropped packets.
//  Timeout: counter clears on every rx_valid; increments while in B1/B2; reaching TIMEOUT returns to B0,
//   discarding the partial packet, with no sync_err. Counter held 0 in B0.
//  rx_valid in the same cycle the timeout fires: the byte is processed as B0 (timeout wins, then byte is framed).
//  Back-to-back rx_valid on consecutive cycles is legal; every strobe is consumed, no backpressure.
//  rst_n low mid-packet: partial packet discarded, cursor returns to X_INIT/Y_INIT.
//  Pulses (click_pulse, pkt_done, sync_err) are high exactly one cycle, 0 otherwise.
// STRUCTURE
//  Shared package calc_pkg: SCREEN_W, SCREEN_H, SymbolSize, button-grid origins, and the
//   symbol codes 97..101 and 103, so tracker, calculator and renderer agree on geometry.
//  One sub-module, axis_clamp_acc: combinational pos + signed delta with clamp to [0, LIMIT-1]; instantiated for X and for Y
//   (Y is given the negated delta).
//  FSM, byte registers, timeout counter and edge detector live in the top module.
// TESTING
//  Reset -> mousex=320, mousey=240, mouseclick=0, no pulses for 10 clk.
//  Packet 08,05,03 -> one clk after byte 3: mousex=325, mousey=237, pkt_done=1, click_pulse=0.
//  Packet 09,00,00 then 09,00,00 -> click_pulse high once (first packet only), mouseclick stays 1.
//  Packet 18,00,00 (dx=-256) applied twice from X=320 -> X=64 then 0 (clamped).
//   Packet 28,00,00 (dy=-256) from Y=240 -> Y=479 (clamped).
//  Byte 00 in B0 -> sync_err pulse, state stays B0. Next valid packet 08,01,00 applies normally (X+1).
//  08,10 then TIMEOUT idle cycles, then 08,02,00 -> only +2 applied, no stray update.
//   Also: rst_n low between bytes 2 and 3 -> cursor 320/240, trailing byte 3 value framed as B0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared geometry, symbol codes and PS/2 packet types for the tracker,
// calculator and renderer.
package calc_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned X_INIT      = 320;
  localparam int unsigned Y_INIT      = 240;
  localparam int unsigned TIMEOUT_CYC = 100000;

  localparam int unsigned SYMBOL_SIZE = 32;
  localparam int unsigned GRID_X0     = 192;
  localparam int unsigned GRID_Y0     = 160;

  localparam logic [7:0] SYM_A = 8'd97;
  localparam logic [7:0] SYM_B = 8'd98;
  localparam logic [7:0] SYM_C = 8'd99;
  localparam logic [7:0] SYM_D = 8'd100;
  localparam logic [7:0] SYM_E = 8'd101;
  localparam logic [7:0] SYM_G = 8'd103;

  localparam int unsigned POS_W  = 10;
  // Wide enough for pos (0..1023) plus/minus a 9-bit delta without wrapping.
  localparam int unsigned CALC_W = 12;

  typedef enum logic [1:0] {
    ST_B0 = 2'd0,
    ST_B1 = 2'd1,
    ST_B2 = 2'd2
  } state_e;

  // First byte of a PS/2 movement packet.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic sync;
    logic middle;
    logic right;
    logic left;
  } flags_t;

endpackage

// File: rtl/axis_clamp_acc.sv
// Combinational cursor axis update: pos + signed delta, clamped to [0, LIMIT-1].
// Ports: pos (current position), delta (signed step), next_pos_c (clamped result).
module axis_clamp_acc
  import calc_pkg::*;
#(
  parameter int unsigned LIMIT = SCREEN_W
) (
  input  logic        [POS_W-1:0]  pos,
  input  logic signed [CALC_W-1:0] delta,
  output logic        [POS_W-1:0]  next_pos_c
);

  localparam logic signed [CALC_W-1:0] MAX_POS = CALC_W'(LIMIT - 1);

  logic signed [CALC_W-1:0] sum;

  always_comb begin
    sum        = $signed({{(CALC_W-POS_W){1'b0}}, pos}) + delta;
    next_pos_c = sum[POS_W-1:0];
    if (sum[CALC_W-1])       next_pos_c = '0;
    else if (sum > MAX_POS)  next_pos_c = MAX_POS[POS_W-1:0];
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped absolute cursor plus
// button levels and one-cycle event pulses.
// Ports: clk, rst_n (sync, active-low); rx_byte/rx_valid from the byte
// receiver; mousex/mousey cursor; mouseclick/right_click button levels;
// click_pulse, pkt_done, sync_err one-cycle pulses.
module mouse_packet_tracker
  import calc_pkg::*;
#(
  parameter int unsigned SCREEN_W_P = SCREEN_W,
  parameter int unsigned SCREEN_H_P = SCREEN_H,
  parameter int unsigned X_INIT_P   = X_INIT,
  parameter int unsigned Y_INIT_P   = Y_INIT,
  parameter int unsigned TIMEOUT    = TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [POS_W-1:0] mousex,
  output logic [POS_W-1:0] mousey,
  output logic             mouseclick,
  output logic             right_click,
  output logic             click_pulse,
  output logic             pkt_done,
  output logic             sync_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state, state_nxt;
  flags_t             flags;
  logic [7:0]         x_byte;
  logic [CNT_W-1:0]   idle_cnt;

  logic               timeout_c;
  state_e             eff_state_c;
  logic               take_b0_c, take_b1_c, apply_c, sync_err_c;
  logic signed [CALC_W-1:0] dx_c, dy_c, dy_neg_c;
  logic [POS_W-1:0]   nx_c, ny_c;

  // Timeout takes priority: a byte arriving as it fires is framed as byte 0.
  assign timeout_c   = (state != ST_B0) && (idle_cnt >= CNT_W'(TIMEOUT));
  assign eff_state_c = timeout_c ? ST_B0 : state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_B0;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = eff_state_c;
    if (rx_valid) begin
      case (eff_state_c)
        ST_B0:   state_nxt = rx_byte[3] ? ST_B1 : ST_B0;
        ST_B1:   state_nxt = ST_B2;
        ST_B2:   state_nxt = ST_B0;
        default: state_nxt = ST_B0;
      endcase
    end
  end

  // FSM control outputs
  always_comb begin
    take_b0_c  = 1'b0;
    take_b1_c  = 1'b0;
    apply_c    = 1'b0;
    sync_err_c = 1'b0;
    if (rx_valid) begin
      case (eff_state_c)
        ST_B0: begin
          take_b0_c  = rx_byte[3];
          sync_err_c = ~rx_byte[3];
        end
        ST_B1:   take_b1_c = 1'b1;
        ST_B2:   apply_c   = 1'b1;
        default: ;
      endcase
    end
  end

  // Idle counter between bytes of a packet
  always_ff @(posedge clk) begin
    if (!rst_n)                                    idle_cnt <= '0;
    else if (rx_valid || timeout_c || state == ST_B0) idle_cnt <= '0;
    else                                           idle_cnt <= idle_cnt + CNT_W'(1);
  end

  // 9-bit two's complement deltas; overflow forces the axis to zero.
  always_comb begin
    dx_c     = flags.x_ovf ? '0 : {{(CALC_W-8){flags.x_sign}}, x_byte};
    dy_c     = flags.y_ovf ? '0 : {{(CALC_W-8){flags.y_sign}}, rx_byte};
    dy_neg_c = -dy_c;
  end

  axis_clamp_acc #(.LIMIT(SCREEN_W_P)) u_x_acc (
    .pos        (mousex),
    .delta      (dx_c),
    .next_pos_c (nx_c)
  );

  // PS/2 Y grows upward while screen Y grows downward.
  axis_clamp_acc #(.LIMIT(SCREEN_H_P)) u_y_acc (
    .pos        (mousey),
    .delta      (dy_neg_c),
    .next_pos_c (ny_c)
  );

  // Byte capture, packet apply and pulse outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags       <= '0;
      x_byte      <= '0;
      mousex      <= POS_W'(X_INIT_P);
      mousey      <= POS_W'(Y_INIT_P);
      mouseclick  <= 1'b0;
      right_click <= 1'b0;
      click_pulse <= 1'b0;
      pkt_done    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      click_pulse <= 1'b0;
      pkt_done    <= 1'b0;
      sync_err    <= sync_err_c;
      if (take_b0_c) flags  <= flags_t'(rx_byte);
      if (take_b1_c) x_byte <= rx_byte;
      if (apply_c) begin
        mousex      <= nx_c;
        mousey      <= ny_c;
        mouseclick  <= flags.left;
        right_click <= flags.right;
        pkt_done    <= 1'b1;
        click_pulse <= flags.left & ~mouseclick;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Randomized and directed bench for mouse_packet_tracker against a
// packet-level reference model.
module tb_mouse_packet_tracker;

  localparam int TB_TIMEOUT = 40;
  localparam int W = 640;
  localparam int H = 480;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] mousex, mousey;
  logic       mouseclick, right_click, click_pulse, pkt_done, sync_err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int   cyc = 0;
  int   m_x = 320, m_y = 240;
  bit   m_l = 0, m_r = 0, m_cp = 0, m_pd = 0, m_se = 0;
  logic [7:0] part[$];
  int   last_t = 0;

  always #5 clk = ~clk;

  mouse_packet_tracker #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .mousex      (mousex),
    .mousey      (mousey),
    .mouseclick  (mouseclick),
    .right_click (right_click),
    .click_pulse (click_pulse),
    .pkt_done    (pkt_done),
    .sync_err    (sync_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int size);
    if (v < 0) return 0;
    if (v > size - 1) return size - 1;
    return v;
  endfunction

  // Packet-level model: one call per clock edge.
  task automatic model(input bit v, input logic [7:0] b, input bit r);
    int dx, dy;
    m_cp = 0; m_pd = 0; m_se = 0;
    if (!r) begin
      part.delete();
      m_x = 320; m_y = 240; m_l = 0; m_r = 0;
      return;
    end
    if (!v) return;
    if (part.size() > 0 && (cyc - last_t) > TB_TIMEOUT) part.delete();
    last_t = cyc;
    if (part.size() == 0) begin
      if (b[3]) part.push_back(b);
      else      m_se = 1;
      return;
    end
    part.push_back(b);
    if (part.size() == 3) begin
      dx = part[0][6] ? 0 : (part[0][4] ? int'(part[1]) - 256 : int'(part[1]));
      dy = part[0][7] ? 0 : (part[0][5] ? int'(part[2]) - 256 : int'(part[2]));
      m_x  = clamp(m_x + dx, W);
      m_y  = clamp(m_y - dy, H);
      m_cp = part[0][0] && !m_l;
      m_l  = part[0][0];
      m_r  = part[0][1];
      m_pd = 1;
      part.delete();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit r);
    @(negedge clk);
    rx_valid = v; rx_byte = b; rst_n = r;
    @(posedge clk);
    cyc++;
    model(v, b, r);
    #1;
    check("mousex", int'(mousex), m_x);
    check("mousey", int'(mousey), m_y);
    check("mouseclick", int'(mouseclick), int'(m_l));
    check("right_click", int'(right_click), int'(m_r));
    check("click_pulse", int'(click_pulse), int'(m_cp));
    check("pkt_done", int'(pkt_done), int'(m_pd));
    check("sync_err", int'(sync_err), int'(m_se));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1);
  endtask

  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    step(1, b0, 1); step(1, b1, 1); step(1, b2, 1);
  endtask

  initial begin
    // Reset, then quiet period
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    check("rst_x", int'(mousex), 320);
    check("rst_y", int'(mousey), 240);
    idle(10);

    pkt(8'h08, 8'h05, 8'h03);
    check("pkt1_x", int'(mousex), 325);
    check("pkt1_y", int'(mousey), 237);
    check("pkt1_done", int'(pkt_done), 1);
    idle(2);

    pkt(8'h09, 8'h00, 8'h00);
    check("click1", int'(click_pulse), 1);
    pkt(8'h09, 8'h00, 8'h00);
    check("click2", int'(click_pulse), 0);
    check("click_lvl", int'(mouseclick), 1);
    idle(1);

    // Clamp at the left and bottom edges
    step(0, 8'h00, 0);
    pkt(8'h18, 8'h00, 8'h00);
    check("xneg1", int'(mousex), 64);
    pkt(8'h18, 8'h00, 8'h00);
    check("xneg2", int'(mousex), 0);
    pkt(8'h28, 8'h00, 8'h00);
    check("yclamp", int'(mousey), 479);

    // Framing error, then recovery
    step(1, 8'h00, 1);
    check("sync_err", int'(sync_err), 1);
    pkt(8'h08, 8'h01, 8'h00);
    check("resync_x", int'(mousex), 1);

    // Exactly TIMEOUT idle cycles abandons the partial packet
    step(1, 8'h08, 1); step(1, 8'h10, 1);
    idle(TB_TIMEOUT);
    pkt(8'h08, 8'h02, 8'h00);
    check("timeout_x", int'(mousex), 3);
    // One fewer idle cycle keeps it
    step(1, 8'h08, 1); step(1, 8'h04, 1);
    idle(TB_TIMEOUT - 1);
    step(1, 8'h00, 1);
    check("no_timeout_x", int'(mousex), 7);

    // Overflow bits zero the delta but still apply buttons
    pkt(8'hCA, 8'h7F, 8'h7F);
    check("ovf_x", int'(mousex), 7);
    check("ovf_r", int'(right_click), 1);

    // Reset mid-packet; trailing byte is framed as byte 0
    step(1, 8'h08, 1); step(1, 8'h20, 1);
    step(0, 8'h00, 0);
    step(1, 8'h03, 1);
    check("midrst_x", int'(mousex), 320);
    check("midrst_se", int'(sync_err), 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int kind;
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        step(0, 8'h00, 0);
      end else if (kind == 1) begin
        step(1, 8'($urandom()), 1);
      end else begin
        logic [7:0] b0;
        b0 = 8'($urandom()) | 8'h08;
        if ($urandom_range(0, 3) == 0) b0 = b0 & 8'h3F;
        for (int k = 0; k < 3; k++) begin
          int gap;
          gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TB_TIMEOUT - 1, TB_TIMEOUT + 1))
                                             : int'($urandom_range(0, 2));
          if (k > 0) idle(gap);
          step(1, (k == 0) ? b0 : 8'($urandom()), 1);
        end
      end
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
